// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle add/subtract sequencer: time-shares one external 4-bit CLA adder,
// one nibble per clock (LSN first), carrying between nibbles in c_reg.
module nibble_serial_adder_ctrl #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic [3:0]             add_in1,
    output logic [3:0]             add_in2,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned KW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic            accept;
    logic            last;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            c_reg;
    logic [KW-1:0]   k;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (k == KW'(NIBBLES - 1)) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Adder ports are driven from registers only, so no input port reaches them.
    always_comb begin
        add_in1 = '0;
        add_in2 = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_cin = c_reg;
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (k == KW'(i)) begin
                    add_in1 = a_reg[4*i +: 4];
                    add_in2 = b_reg[4*i +: 4];
                end
            end
        end
    end

    // The operation type lives entirely in the inverted b_reg and the initial
    // carry, so no separate subtract flag needs to be kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= 1'b0;
            k         <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_reg <= op_a;
                b_reg <= sub ? ~op_b : op_b;
                c_reg <= sub;
                k     <= '0;
            end else if (state == RUN) begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (k == KW'(i)) begin
                        result[4*i +: 4] <= add_sum;
                    end
                end
                c_reg <= add_cout;
                k     <= k + 1'b1;
                if (last) begin
                    carry_out <= add_cout;
                    overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl; supplies a behavioural 4-bit
// adder and compares against an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;
    localparam int          LAT     = NIBBLES + 1;
    localparam int          SMAX    = (2 ** (W - 1)) - 1;
    localparam int          SMIN    = -(2 ** (W - 1));

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;
    logic [3:0]   add_in1, add_in2, add_sum;
    logic         add_cin, add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_in1} + {1'b0, add_in2} + {4'b0, add_cin};

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // Reference: {carry/no-borrow, W-bit result}
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] d;
        if (!s) return {1'b0, a} + {1'b0, b};
        d = a - b;
        return {(a >= b), d};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = s ? (sa - sb) : (sa + sb);
        return (r > SMAX) || (r < SMIN);
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] v, input int unsigned j);
        logic [W-1:0] t;
        t = v >> (4 * j);
        return t[3:0];
    endfunction

    // Carry into nibble j of a + (b or ~b) + s, from the low-order arithmetic.
    function automatic logic model_cin(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                       input int unsigned j);
        longint unsigned m, bb, t;
        m  = longint'(1) << (4 * j);
        bb = s ? longint'(~b) : longint'(b);
        t  = (longint'(a) % m) + (bb % m) + longint'(s);
        return ((t >> (4 * j)) & 1) != 0;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(posedge clk); #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op_a = 16'h1234; op_b = 16'h0001;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        end
        checks++;
        if ({result, carry_out, overflow} !== '0) begin
            errors++; $display("FAIL reset_result: result=%h c=%b v=%b required 0", result, carry_out, overflow);
        end
        checks++;
        if ({add_in1, add_in2, add_cin} !== 9'd0) begin
            errors++; $display("FAIL reset_adder_ports: %h %h %b required 0", add_in1, add_in2, add_cin);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_basic_add();
        logic [W-1:0] a, b;
        logic [W:0]   m;
        a = 16'h1234; b = 16'h0FFF;
        m = model_sum(a, b, 1'b0);
        issue(a, b, 1'b0);
        for (int unsigned j = 0; j < NIBBLES; j++) begin
            @(negedge clk);
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++; $display("FAIL basic_busy[%0d]: busy/done=%b required 10", j, {busy, done});
            end
            checks++;
            if ({add_in1, add_in2, add_cin} !== {nib(a, j), nib(b, j), model_cin(a, b, 1'b0, j)}) begin
                errors++; $display("FAIL basic_nibble[%0d]: in1=%h in2=%h cin=%b required %h %h %b",
                                   j, add_in1, add_in2, add_cin, nib(a, j), nib(b, j), model_cin(a, b, 1'b0, j));
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++; $display("FAIL basic_done: busy/done=%b required 01", {busy, done});
        end
        checks++;
        if ({carry_out, result, overflow} !== {m, model_ovf(a, b, 1'b0)}) begin
            errors++; $display("FAIL basic_result: result=%h c=%b v=%b required %h %b %b",
                               result, carry_out, overflow, m[W-1:0], m[W], model_ovf(a, b, 1'b0));
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || result !== m[W-1:0]) begin
            errors++; $display("FAIL basic_hold: done=%b result=%h required 0 %h", done, result, m[W-1:0]);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[$], vb[$];
        logic         vs[$];
        logic [W:0]   m;
        logic         v;
        int           lat;
        va = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 24; i++) begin
            va.push_back(pick()); vb.push_back(pick()); vs.push_back(1'($urandom));
        end
        for (int i = 0; i < va.size(); i++) begin
            m = model_sum(va[i], vb[i], vs[i]);
            v = model_ovf(va[i], vb[i], vs[i]);
            issue(va[i], vb[i], vs[i]);
            wait_done(lat);
            checks++;
            if (lat != LAT || done !== 1'b1) begin
                errors++; $display("FAIL vec%0d_latency: %0d cycles done=%b required %0d", i, lat, done, LAT);
            end
            checks++;
            if ({carry_out, result, overflow} !== {m, v}) begin
                errors++; $display("FAIL vec%0d_result: %h %s %h -> result=%h c=%b v=%b required %h %b %b",
                                   i, va[i], vs[i] ? "-" : "+", vb[i], result, carry_out, overflow, m[W-1:0], m[W], v);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        int           n_done;
        logic [W-1:0] got;
        n_done = 0; got = 'x;
        issue(16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; sub = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_start_busy: busy=%b required 1", busy);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++; got = result;
            end
        end
        checks++;
        if (n_done != 1) begin
            errors++; $display("FAIL busy_done_count: %0d pulses required 1", n_done);
        end
        checks++;
        if (got !== 16'h0002) begin
            errors++; $display("FAIL busy_result: result=%h required 0002", got);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        start = 1'b1; op_a = 16'h00FF; op_b = 16'h0001; sub = 1'b0;
        @(posedge clk); #1;
        op_a = 16'h1000; op_b = 16'h0001; sub = 1'b1;
        wait_done(lat1);
        checks++;
        if (lat1 != LAT || result !== 16'h0100) begin
            errors++; $display("FAIL b2b_first: lat=%0d result=%h required %0d 0100", lat1, result, LAT);
        end
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat2);
        checks++;
        if (lat2 != LAT || done !== 1'b1) begin
            errors++; $display("FAIL b2b_spacing: %0d cycles required %0d", lat2, LAT);
        end
        checks++;
        if ({result, carry_out, overflow} !== {16'h0FFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL b2b_second: result=%h c=%b v=%b required 0fff 1 0", result, carry_out, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n_done, lat;
        n_done = 0;
        issue(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, carry_out, overflow} !== '0) begin
            errors++; $display("FAIL rstmid_clear: busy=%b done=%b result=%h c=%b v=%b required all 0",
                               busy, done, result, carry_out, overflow);
        end
        checks++;
        if ({add_in1, add_in2, add_cin} !== 9'd0) begin
            errors++; $display("FAIL rstmid_ports: %h %h %b required 0", add_in1, add_in2, add_cin);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++; $display("FAIL rstmid_no_done: %0d pulses required 0", n_done);
        end
        issue(16'h0003, 16'h0004, 1'b0);
        wait_done(lat);
        checks++;
        if (lat != LAT || result !== 16'h0007) begin
            errors++; $display("FAIL rstmid_recover: lat=%0d result=%h required %0d 0007", lat, result, LAT);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_add();
        test_vectors();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
